// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - DEF_CLK_FREQ_HZ / DEF_BAUD : default clock and line rate
//   - rx_state_t                 : receiver FSM state encoding
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ_HZ = 24000000;
    localparam int unsigned DEF_BAUD        = 115200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with (AW+1)-bit wrapping pointers.
//   clock, reset       : clock, synchronous active-high reset
//   wr_en, wr_data     : push request and data (accepted when not full,
//                        or when full and a pop happens the same cycle)
//   rd_en              : pop request (ignored when empty)
//   rd_data            : head entry, combinational; 0 while empty
//   empty, full, level : status derived from the pointers
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [0:(1 << AW) - 1];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    assign do_rd = rd_en && !empty;
    // When full, a simultaneous pop frees the slot being overwritten.
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a 2^FIFO_AW entry FIFO.
//   clock, reset          : clock, synchronous active-high reset
//   uart_rx               : asynchronous serial input, idle high
//   rx_data, rx_valid     : FIFO head and not-empty indication
//   rx_ready              : pop strobe (pops when rx_valid is also high)
//   err_clr               : clears the sticky error flags
//   framing_err, overrun_err, parity_err : sticky error flags
//   fifo_level            : current FIFO occupancy
// Build option: define UART_RX_PARITY_EN to receive one even-parity bit
// between the data and the stop bit; otherwise parity_err is tied to 0.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int unsigned BAUD        = DEF_BAUD,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               uart_rx,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    input  logic               err_clr,
    output logic               framing_err,
    output logic               overrun_err,
    output logic               parity_err,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit_tick;
    logic          half_tick;
    logic          push;
    logic          pop;
    logic          frm_set;
    logic          ovr_set;
    logic          fifo_empty;
    logic          fifo_full;

    always_ff @(posedge clock) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[0], uart_rx};
    end
    assign rx_s = sync_q[1];

    assign bit_tick  = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign half_tick = (cnt_q == CW'(HALF - 1));

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic par_set;
    logic par_bad;

    // Even parity: data bits plus parity bit must hold an even count of ones.
    assign par_bad = ^{shift_q, par_q};

    always_ff @(posedge clock) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_d;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        frm_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        par_set = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (half_tick) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line back high at mid start bit is treated as a glitch.
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    // Back to IDLE on the sample itself so a following start
                    // bit right after a single stop bit is not missed.
                    state_d = ST_IDLE;
                    frm_set = !rx_s;
`ifdef UART_RX_PARITY_EN
                    par_set = par_bad;
                    push    = rx_s && !par_bad;
`else
                    push    = rx_s;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_valid = !fifo_empty;
    assign pop      = rx_valid && rx_ready;
    assign ovr_set  = push && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (shift_q),
        .rd_en   (pop),
        .rd_data (rx_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    // Sticky flags: a set event outranks err_clr in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (frm_set)      framing_err <= 1'b1;
            else if (err_clr) framing_err <= 1'b0;
            if (ovr_set)      overrun_err <= 1'b1;
            else if (err_clr) overrun_err <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset)        parity_err <= 1'b0;
        else if (par_set) parity_err <= 1'b1;
        else if (err_clr) parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 24000000, meaning the clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line rate in bit/s.
REQ-003 SHALL have parameter FIFO_AW, default 4, meaning log2 of the FIFO depth (16 entries).
REQ-004 SHALL have port clock, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port uart_rx, input, 1, the asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data, output, 8, the FIFO head byte.
REQ-008 SHALL have port rx_valid, output, 1, asserted when the FIFO is not empty.
REQ-009 SHALL have port rx_ready, input, 1, the consumer pop strobe.
REQ-010 SHALL have port err_clr, input, 1, which clears the sticky error flags.
REQ-011 SHALL have port framing_err, output, 1, a sticky flag.
REQ-012 SHALL have port overrun_err, output, 1, a sticky flag.
REQ-013 SHALL have port parity_err, output, 1, a sticky flag.
REQ-014 SHALL have port fifo_level, output, FIFO_AW+1, the current entry count.

Function
REQ-015 SHALL pass uart_rx through a 2-flop synchronizer preset to 1; all decoding SHALL use the synchronized value.
REQ-016 SHALL compute CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer truncation, 208 at defaults) and HALF = CLKS_PER_BIT/2.
REQ-017 SHALL implement the FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
REQ-018 SHALL move from IDLE to START when the synchronized line is 0, then wait HALF clocks.
REQ-019 SHALL, at the end of START, go to DATA if the line is still 0; otherwise it SHALL return to IDLE with no flag set (glitch rejection).
REQ-020 SHALL, in DATA, sample 8 bits LSB-first, one every CLKS_PER_BIT clocks, with the 3-bit bit counter wrapping at 7 into the next state.
REQ-021 SHALL, in STOP, sample after CLKS_PER_BIT; a sample of 1 SHALL push the byte, and a sample of 0 SHALL set framing_err and discard the byte.
REQ-022 SHALL return to IDLE in the same cycle as the stop sample, so back-to-back frames with 1 stop bit are received.
REQ-023 SHALL make a pushed byte visible as rx_valid=1 on the cycle after the stop-sample cycle.
REQ-024 SHALL pop the FIFO when rx_valid && rx_ready; rx_data SHALL show the head combinationally from the registered array and read pointer.
REQ-025 SHALL, on a push when full (fifo_level = 2^FIFO_AW) with no pop that cycle, drop the byte, set overrun_err and leave the contents unchanged.
REQ-026 SHALL, on a push when full coincident with a pop, accept the byte with level unchanged and no overrun.
REQ-027 SHALL, on simultaneous push and pop when not full, keep the level unchanged.
REQ-028 SHALL use (FIFO_AW+1)-bit pointers that wrap modulo 2^(FIFO_AW+1); full/empty SHALL be derived from the pointers.
REQ-029 SHALL have err_clr clear all sticky flags; a flag-set event in the same cycle SHALL win.

Reset
REQ-030 SHALL, on reset, go to IDLE with the FIFO empty and rx_valid=0, fifo_level=0, rx_data=0, all error flags 0, counters 0 and the synchronizer at 1.
REQ-031 SHALL, on reset mid-frame, abandon the partial byte with no push and no flag.

Configuration
REQ-032 SHALL, with UART_RX_PARITY_EN defined, receive one even-parity bit in a PARITY state between DATA and STOP; a mismatch SHALL set parity_err and discard the byte, and if the stop bit is also 0, framing_err SHALL be set as well.
REQ-033 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and tie parity_err to 0.

Structure
REQ-034 SHALL place the FSM state enum and the default CLK_FREQ_HZ/BAUD constants in the shared package uart_pkg.
REQ-035 SHALL implement the FIFO as one sub-module, sync_fifo, parameterized by width 8 and FIFO_AW.

Verification (CLK_FREQ_HZ=16, BAUD=1, so CLKS_PER_BIT=16)
REQ-036 SHALL verify that frame 0x55 with stop=1 gives rx_valid rising 1 cycle after the stop sample, rx_data=0x55 and fifo_level=1.
REQ-037 SHALL verify that a 4-clock low glitch in idle gives no push and no flags.
REQ-038 SHALL verify that frame 0xA3 with stop=0 gives framing_err=1, level unchanged, and err_clr returns it to 0.
REQ-039 SHALL verify that 17 frames 0x00..0x10 with rx_ready=0 give level 16, overrun_err=1 and the head reading 0x00; popping 16 times SHALL yield 0x00..0x0F.
REQ-040 SHALL verify that with rx_ready held 1, back-to-back frames 0x12, 0x34 are each popped with level peaking at 1.
REQ-041 SHALL verify, with UART_RX_PARITY_EN, that 0x07 with parity 0 sets parity_err and no push, while parity 1 pushes 0x07.
